// File: rtl/tspi_pkg.sv
// tspi_pkg: shared frame geometry and state type for the Tri-SPI receiver.
// Imported by tspi_rx and tspi_rx_sync.
package tspi_pkg;
  localparam int FRAME_BITS = 288;
  localparam int PIX_BITS   = 234;
  localparam int NUM_GRIDS  = 52;
  localparam int ROW_COUNT  = 39;
  localparam int COL_COUNT  = 6;
  localparam int GRAY_W     = 3;

  typedef enum logic {
    WAIT_LAT,
    SHIFT
  } rx_state_e;
endpackage

// File: rtl/tspi_rx_sync.sv
// tspi_rx_sync: W-bit 2-FF synchronizer; the low EW bits also get
// rising-edge detection, the remaining bits are passed out as levels.
module tspi_rx_sync #(
  parameter int W  = 5,
  parameter int EW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    d,
  output logic [W-EW-1:0] lvl,
  output logic [EW-1:0]   rise
);
  logic [W-1:0]  m_q, m_d;
  logic [W-1:0]  s_q, s_d;
  logic [EW-1:0] p_q, p_d;

  // advance the synchronizer chain and edge history
  always_comb begin
    m_d = d;
    s_d = m_q;
    p_d = s_q[EW-1:0];
  end

  // chain registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0;
      s_q <= '0;
      p_q <= '0;
    end else begin
      m_q <= m_d;
      s_q <= s_d;
      p_q <= p_d;
    end
  end

  assign lvl  = s_q[W-1:EW];
  assign rise = s_q[EW-1:0] & ~p_q;
endmodule

// File: rtl/tspi_rx.sv
// tspi_rx: Tri-SPI frame receiver / checker.
// Optional GCP pulse checking is built when TSPI_RX_GCP_CHECK_EN is defined.
module tspi_rx #(
  parameter int FRAME_BITS = tspi_pkg::FRAME_BITS,
  parameter int PIX_BITS   = tspi_pkg::PIX_BITS,
  parameter int NUM_GRIDS  = tspi_pkg::NUM_GRIDS
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SCK,
  input  logic       S1,
  input  logic       S2,
  input  logic       S3,
  input  logic       LAT,
  input  logic       GCP,
  output logic       PIX_WE,
  output logic [5:0] PIX_ROW,
  output logic [2:0] PIX_COL,
  output logic [2:0] PIX_GRAY,
  output logic       FRAME_VALID,
  output logic [5:0] GRID_N,
  output logic       LEN_ERR,
  output logic       GRID_ERR,
  output logic [3:0] GCP_CNT,
  output logic       GCP_ERR
);
  import tspi_pkg::*;

  localparam logic [8:0] FRAME_B  = 9'(FRAME_BITS);
  localparam logic [8:0] PIX_B    = 9'(PIX_BITS);
  localparam logic [8:0] BC_MAX   = 9'(FRAME_BITS + 1);
  localparam logic [6:0] GRID_LIM = 7'(NUM_GRIDS);
  localparam logic [2:0] COL_LAST = 3'(COL_COUNT - 1);

`ifdef TSPI_RX_GCP_CHECK_EN
  localparam int EW = 3;
`else
  localparam int EW = 2;
`endif

  logic [GRAY_W+EW-1:0] sync_in;
  logic [GRAY_W-1:0]    lanes;
  logic [EW-1:0]        rise;
  logic                 sck_rise, lat_rise;

`ifdef TSPI_RX_GCP_CHECK_EN
  logic       gcp_rise;
  logic [3:0] gcp_cnt_q, gcp_cnt_d;
  logic [3:0] gcp_out_q, gcp_out_d;
  logic       gcp_err_q, gcp_err_d;
  assign sync_in  = {S3, S2, S1, GCP, LAT, SCK};
  assign gcp_rise = rise[2];
  assign GCP_CNT  = gcp_out_q;
  assign GCP_ERR  = gcp_err_q;
`else
  logic unused_gcp;
  assign sync_in    = {S3, S2, S1, LAT, SCK};
  assign unused_gcp = GCP;
  assign GCP_CNT    = '0;
  assign GCP_ERR    = 1'b0;
`endif

  assign sck_rise = rise[0];
  assign lat_rise = rise[1];

  tspi_rx_sync #(
    .W  (GRAY_W + EW),
    .EW (EW)
  ) u_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (sync_in),
    .lvl   (lanes),
    .rise  (rise)
  );

  rx_state_e  state_q, state_d;
  logic [8:0] bc_q, bc_d;
  logic [5:0] row_q, row_d;
  logic [2:0] col_q, col_d;
  logic [5:0] first_q, first_d;
  logic [5:0] second_q, second_d;
  logic [1:0] nset_q, nset_d;
  logic       mis_q, mis_d;
  logic       we_q, we_d;
  logic [5:0] prow_q, prow_d;
  logic [2:0] pcol_q, pcol_d;
  logic [2:0] gray_q, gray_d;
  logic       fv_q, fv_d;
  logic [5:0] grid_q, grid_d;
  logic       len_q, len_d;
  logic       gerr_q, gerr_d;
  logic [8:0] goff;

  assign goff = bc_q - PIX_B;

  // bit processing first, then latch report and counter clear
  always_comb begin
    state_d  = state_q;
    bc_d     = bc_q;
    row_d    = row_q;
    col_d    = col_q;
    first_d  = first_q;
    second_d = second_q;
    nset_d   = nset_q;
    mis_d    = mis_q;
    we_d     = 1'b0;
    prow_d   = prow_q;
    pcol_d   = pcol_q;
    gray_d   = gray_q;
    fv_d     = 1'b0;
    grid_d   = grid_q;
    len_d    = len_q;
    gerr_d   = gerr_q;
`ifdef TSPI_RX_GCP_CHECK_EN
    gcp_cnt_d = gcp_cnt_q;
    gcp_out_d = gcp_out_q;
    gcp_err_d = gcp_err_q;
`endif
    if (state_q == SHIFT) begin
      if (sck_rise) begin
        if (bc_q != BC_MAX) bc_d = bc_q + 9'd1;
        if (bc_q < PIX_B) begin
          we_d   = 1'b1;
          prow_d = row_q;
          pcol_d = col_q;
          gray_d = lanes;
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 6'd1;
          end else begin
            col_d = col_q + 3'd1;
          end
        end else if (bc_q < FRAME_B) begin
          if (&lanes) begin
            if (nset_q == 2'd0) first_d = goff[5:0];
            if (nset_q == 2'd1) second_d = goff[5:0];
            if (nset_q != 2'd3) nset_d = nset_q + 2'd1;
          end else if (|lanes) begin
            mis_d = 1'b1;
          end
        end
      end
`ifdef TSPI_RX_GCP_CHECK_EN
      if (gcp_rise && gcp_cnt_q != 4'd15)
        gcp_cnt_d = gcp_cnt_q + 4'd1;
`endif
      if (lat_rise) begin
        fv_d   = 1'b1;
        grid_d = first_d;
        len_d  = (bc_d != FRAME_B);
        gerr_d = (nset_d != 2'd2)
              || (second_d != first_d + 6'd1)
              || ({1'b0, first_d} + 7'd1 >= GRID_LIM)
              || mis_d;
`ifdef TSPI_RX_GCP_CHECK_EN
        gcp_out_d = gcp_cnt_d;
        gcp_err_d = (gcp_cnt_d != 4'd6);
`endif
      end
    end else if (lat_rise) begin
      state_d = SHIFT;
    end
    if (lat_rise) begin
      bc_d     = '0;
      row_d    = '0;
      col_d    = '0;
      first_d  = '0;
      second_d = '0;
      nset_d   = '0;
      mis_d    = 1'b0;
`ifdef TSPI_RX_GCP_CHECK_EN
      gcp_cnt_d = '0;
`endif
    end
  end

  // state, counters and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= WAIT_LAT;
      bc_q     <= '0;
      row_q    <= '0;
      col_q    <= '0;
      first_q  <= '0;
      second_q <= '0;
      nset_q   <= '0;
      mis_q    <= 1'b0;
      we_q     <= 1'b0;
      prow_q   <= '0;
      pcol_q   <= '0;
      gray_q   <= '0;
      fv_q     <= 1'b0;
      grid_q   <= '0;
      len_q    <= 1'b0;
      gerr_q   <= 1'b0;
`ifdef TSPI_RX_GCP_CHECK_EN
      gcp_cnt_q <= '0;
      gcp_out_q <= '0;
      gcp_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      bc_q     <= bc_d;
      row_q    <= row_d;
      col_q    <= col_d;
      first_q  <= first_d;
      second_q <= second_d;
      nset_q   <= nset_d;
      mis_q    <= mis_d;
      we_q     <= we_d;
      prow_q   <= prow_d;
      pcol_q   <= pcol_d;
      gray_q   <= gray_d;
      fv_q     <= fv_d;
      grid_q   <= grid_d;
      len_q    <= len_d;
      gerr_q   <= gerr_d;
`ifdef TSPI_RX_GCP_CHECK_EN
      gcp_cnt_q <= gcp_cnt_d;
      gcp_out_q <= gcp_out_d;
      gcp_err_q <= gcp_err_d;
`endif
    end
  end

  assign PIX_WE      = we_q;
  assign PIX_ROW     = prow_q;
  assign PIX_COL     = pcol_q;
  assign PIX_GRAY    = gray_q;
  assign FRAME_VALID = fv_q;
  assign GRID_N      = grid_q;
  assign LEN_ERR     = len_q;
  assign GRID_ERR    = gerr_q;
endmodule

// File: tb/tb_tspi_rx.sv
// tb_tspi_rx: directed scoreboard bench for tspi_rx.
// Pixel writes and frame reports are queued at drive time, checked on output.
module tb_tspi_rx;
  logic       CLK = 0;
  logic       RST_N = 0;
  logic       SCK = 0;
  logic       S1 = 0;
  logic       S2 = 0;
  logic       S3 = 0;
  logic       LAT = 0;
  logic       GCP = 0;
  logic       PIX_WE;
  logic [5:0] PIX_ROW;
  logic [2:0] PIX_COL;
  logic [2:0] PIX_GRAY;
  logic       FRAME_VALID;
  logic [5:0] GRID_N;
  logic       LEN_ERR;
  logic       GRID_ERR;
  logic [3:0] GCP_CNT;
  logic       GCP_ERR;

  tspi_rx dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .SCK         (SCK),
    .S1          (S1),
    .S2          (S2),
    .S3          (S3),
    .LAT         (LAT),
    .GCP         (GCP),
    .PIX_WE      (PIX_WE),
    .PIX_ROW     (PIX_ROW),
    .PIX_COL     (PIX_COL),
    .PIX_GRAY    (PIX_GRAY),
    .FRAME_VALID (FRAME_VALID),
    .GRID_N      (GRID_N),
    .LEN_ERR     (LEN_ERR),
    .GRID_ERR    (GRID_ERR),
    .GCP_CNT     (GCP_CNT),
    .GCP_ERR     (GCP_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [5:0] row;
    logic [2:0] col;
    logic [2:0] gray;
  } pix_t;

  typedef struct packed {
    logic [5:0] grid;
    logic       len;
    logic       gerr;
    logic [3:0] gcnt;
    logic       gcerr;
  } rep_t;

  pix_t pq[$];
  rep_t fq[$];
  int   nvec = 0;
  int   nmis = 0;

  // output monitor: pop and compare on every strobe
  always @(negedge CLK) begin
    pix_t p;
    rep_t r;
    if (RST_N && PIX_WE) begin
      nvec++;
      assert (pq.size() != 0) else begin
        nmis++;
        $error("FAIL pix_extra got r%0d c%0d want none", PIX_ROW, PIX_COL);
      end
      if (pq.size() != 0) begin
        p = pq.pop_front();
        assert ({PIX_ROW, PIX_COL, PIX_GRAY} === p) else begin
          nmis++;
          $error("FAIL pix got r%0d c%0d g%0d want r%0d c%0d g%0d",
                 PIX_ROW, PIX_COL, PIX_GRAY, p.row, p.col, p.gray);
        end
      end
    end
    if (RST_N && FRAME_VALID) begin
      nvec++;
      assert (fq.size() != 0) else begin
        nmis++;
        $error("FAIL frame_extra got grid=%0d want none", GRID_N);
      end
      if (fq.size() != 0) begin
        r = fq.pop_front();
        assert ({GRID_N, LEN_ERR, GRID_ERR, GCP_CNT, GCP_ERR} === r) else begin
          nmis++;
          $error("FAIL report got g%0d l%0d e%0d c%0d ce%0d want g%0d l%0d e%0d c%0d ce%0d",
                 GRID_N, LEN_ERR, GRID_ERR, GCP_CNT, GCP_ERR,
                 r.grid, r.len, r.gerr, r.gcnt, r.gcerr);
        end
      end
    end
  end

  task automatic clk(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic rep_t rep(input int g, input bit len,
                               input bit gerr, input int ng);
    rep_t r;
    r.grid = 6'(g);
    r.len  = len;
    r.gerr = gerr;
`ifdef TSPI_RX_GCP_CHECK_EN
    r.gcnt  = 4'(ng);
    r.gcerr = (ng != 6);
`else
    r.gcnt  = 4'(0 * ng);
    r.gcerr = 1'b0;
`endif
    return r;
  endfunction

  task automatic pulse_lat(input bit push, input rep_t r);
    if (push) fq.push_back(r);
    clk(3);
    LAT = 1;
    clk(3);
    LAT = 0;
    clk(6);
  endtask

  task automatic check_zero(input string tag);
    nvec++;
    assert ({PIX_WE, PIX_ROW, PIX_COL, PIX_GRAY} === 13'd0) else begin
      nmis++;
      $error("FAIL %s_pix got %0h want 0", tag,
             {PIX_WE, PIX_ROW, PIX_COL, PIX_GRAY});
    end
    nvec++;
    assert ({FRAME_VALID, GRID_N, LEN_ERR, GRID_ERR, GCP_CNT, GCP_ERR} === 14'd0)
    else begin
      nmis++;
      $error("FAIL %s_rep got %0h want 0", tag,
             {FRAME_VALID, GRID_N, LEN_ERR, GRID_ERR, GCP_CNT, GCP_ERR});
    end
  endtask

  // mode 0: close with LAT, 1: LAT with last SCK, 2: no LAT
  task automatic frame(input int n, input int ga, input int gb,
                       input int gp, input int ng, input int mode,
                       input rep_t r);
    for (int k = 0; k < n; k++) begin
      logic [2:0] v;
      bit g_on;
      bit l_on;
      if (k < 234) begin
        v = 3'(k % 8);
        pq.push_back(pix_t'({6'(k / 6), 3'(k % 6), v}));
      end else if (k < 288) begin
        if (k - 234 == ga || k - 234 == gb) v = 3'b111;
        else if (k - 234 == gp) v = 3'b011;
        else v = 3'b000;
      end else begin
        v = 3'b111;
      end
      g_on = (k >= 240) && (k < 240 + 2 * ng) && ((k - 240) % 2 == 0);
      l_on = (mode == 1) && (k == n - 1);
      if (l_on) fq.push_back(r);
      {S3, S2, S1} = v;
      clk(3);
      SCK = 1;
      if (g_on) GCP = 1;
      if (l_on) LAT = 1;
      clk(3);
      SCK = 0;
      GCP = 0;
      LAT = 0;
    end
    clk(3);
    if (mode == 0) pulse_lat(1, r);
    else clk(6);
  endtask

  initial begin
    RST_N = 0;
    clk(3);
    check_zero("reset");
    RST_N = 1;
    clk(3);
    pulse_lat(0, rep(0, 0, 0, 0));

    frame(288, 10, 11, -1, 6, 0, rep(10, 0, 0, 6));
    frame(287, 10, 11, -1, 6, 0, rep(10, 1, 0, 6));
    frame(290, 10, 11, -1, 6, 0, rep(10, 1, 0, 6));
    frame(288, 10, 12, -1, 6, 0, rep(10, 0, 1, 6));
    frame(288, -1, -1, 20, 6, 0, rep(0, 0, 1, 6));
    frame(288, 51, 52, -1, 6, 0, rep(51, 0, 1, 6));
    frame(288, 10, 11, -1, 6, 1, rep(10, 0, 0, 6));
    frame(288, 10, 11, -1, 5, 0, rep(10, 0, 0, 5));

    frame(100, 10, 11, -1, 6, 2, rep(0, 0, 0, 0));
    RST_N = 0;
    #2;
    check_zero("midreset");
    clk(3);
    RST_N = 1;
    clk(3);
    pulse_lat(0, rep(0, 0, 0, 0));
    frame(288, 20, 21, -1, 6, 0, rep(20, 0, 0, 6));

    clk(20);
    nvec++;
    assert (pq.size() == 0) else begin
      nmis++;
      $error("FAIL pix_missing got %0d left want 0", pq.size());
    end
    nvec++;
    assert (fq.size() == 0) else begin
      nmis++;
      $error("FAIL frame_missing got %0d left want 0", fq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/tspi_rx.md
# tspi_rx

Tri-SPI receiver and frame checker: the display-side end of the three-lane VFD serial link. It oversamples SCK, S1–S3, LAT and GCP on the system clock and deserializes each 288-bit frame. It emits one 3-bit grayscale pixel write per pixel bit and reports the decoded grid pair and error flags on every latch. It sits on the FPGA output pins in loopback, and in the bench as the reference monitor for the Tri-SPI transmitter.

## Interface
Parameters:
- FRAME_BITS, 288: serial bits per frame (pixel plus grid region).
- PIX_BITS, 234: pixel bits per frame (39 rows × 6 columns).
- NUM_GRIDS, 52: valid grid indices 0..NUM_GRIDS-1; must be ≤ FRAME_BITS-PIX_BITS.

Ports:
- CLK  in  1  system clock (12 MHz); only clock in the block.
- RST_N  in  1  asynchronous, active-low reset.
- SCK  in  1  Tri-SPI serial clock, asynchronous to CLK.
- S1, S2, S3  in  1 each  serial data lanes (grayscale bit 0, 1, 2).
- LAT  in  1  latch strobe, asynchronous.
- GCP  in  1  gradient control pulse, asynchronous.
- PIX_WE  out  1  one-CLK pixel write strobe.
- PIX_ROW  out  6  pixel row 0..38.
- PIX_COL  out  3  pixel column 0..5 within the 6-bit group.
- PIX_GRAY  out  3  {S3,S2,S1} sampled for this pixel.
- FRAME_VALID  out  1  one-CLK strobe on accepted latch.
- GRID_N  out  6  lower set grid index of the latched frame.
- LEN_ERR  out  1  bit count at latch ≠ FRAME_BITS.
- GRID_ERR  out  1  grid region malformed.
- GCP_CNT  out  4  GCP pulses seen since the previous latch.
- GCP_ERR  out  1  GCP_CNT ≠ 6.

All outputs reset to 0.

## Operation
- SCK, S1–S3, LAT and GCP each pass through a 2-FF synchronizer; rising edges are detected on the synchronized SCK, LAT and GCP.
- State machine:
  - WAIT_LAT: entered from reset. Ignores SCK and GCP. The first LAT rise clears all counters, moves to SHIFT and produces no FRAME_VALID.
  - SHIFT: processes SCK and GCP edges. Each LAT rise produces one frame report, clears the counters and stays in SHIFT.
- Bit counter: 9 bits, incremented on each SCK rise, saturating at FRAME_BITS+1.
- Pixel region (bit < PIX_BITS):
  - PIX_WE pulses with the current PIX_ROW, PIX_COL and PIX_GRAY.
  - PIX_COL wraps 5→0; PIX_ROW increments on each wrap.
  - Row and column are incremental counters; no divide or modulo.
- Grid region (PIX_BITS ≤ bit < FRAME_BITS): no PIX_WE. For grid index g = bit-PIX_BITS:
  - If all three lanes are 1: record g (first and second set index, set count).
  - If the lanes disagree: set the lane-mismatch flag.
- Bits at or beyond FRAME_BITS are discarded: no writes and no grid recording.
- Frame report on LAT rise (in SHIFT):
  - FRAME_VALID=1.
  - GRID_N = first set index (0 if none).
  - LEN_ERR = (bit count ≠ FRAME_BITS).
  - GRID_ERR = set count ≠ 2, OR second ≠ first+1, OR first+1 ≥ NUM_GRIDS, OR lane mismatch.
  - GRID_N, LEN_ERR, GRID_ERR, GCP_CNT and GCP_ERR hold until the next report.

## Timing
- Pin-to-output latency is 3 CLK cycles: PIX_WE rises 3 CLK after the SCK pin rise, FRAME_VALID 3 CLK after the LAT pin rise.
- SCK high and low phases must each last ≥ 2 CLK. Data must be stable ≥ 2 CLK before and after the SCK rise.
- SCK edge and LAT edge detected in the same CLK: the bit is processed first and included in the report; the counters then clear.
- GCP edge and LAT edge in the same CLK: the pulse counts toward the closing frame.
- Reset mid-frame: outputs clear immediately, state returns to WAIT_LAT, and the partial frame is never reported.

## Configuration
- TSPI_RX_GCP_CHECK_EN:
  - Defined: GCP is synchronized and counted, saturating at 15; GCP_CNT and GCP_ERR behave as above.
  - Undefined: the GCP input is ignored, no synchronizer is built, and GCP_CNT and GCP_ERR are tied to 0.

## Structure
- Package tspi_pkg holds:
  - FRAME_BITS, PIX_BITS, NUM_GRIDS, ROW_COUNT=39, COL_COUNT=6 and GRAY_W=3.
  - The rx state enum {WAIT_LAT, SHIFT}.
- Sub-module tspi_rx_sync: parameterized-width 2-FF synchronizer plus rising-edge detector. It is instantiated once for the data lanes and the strobes.

## Test plan
- Reset, then LAT, then 288 bits with pixel bit k = k%8 and grid bits 10 and 11 set on all lanes, then LAT → 234 PIX_WE pulses (bit 7: row 1, col 1, gray 7); FRAME_VALID with GRID_N=10, LEN_ERR=0, GRID_ERR=0.
- Same frame but only 287 bits → LEN_ERR=1. Frame with 290 bits → LEN_ERR=1, still exactly 234 PIX_WE.
- Grid bits 10 and 12 set → GRID_ERR=1. Grid bit 20 set only on S1 and S2 → GRID_ERR=1. Grid bits 51 and 52 set → GRID_ERR=1.
- SCK edge coincident with LAT on bit 288 → the bit is counted, LEN_ERR=0.
- Assert RST_N low at bit 100, release, send a full frame → no FRAME_VALID on the first LAT, then a normal report on the second LAT.
- With TSPI_RX_GCP_CHECK_EN defined: 6 GCP pulses per frame → GCP_CNT=6, GCP_ERR=0; 5 pulses → GCP_ERR=1. With the macro undefined: both outputs stay 0.
